// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that launches one byte at a time into a UART transmitter.
// Define UART_TXF_OVF_EN to add the sticky overflow flag (ovfH, cleared by ovfclrH).
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int BUSY_TMO = 8
) (
  input  logic sysclk,
  input  logic sysrstl,
  input  logic wrH,
  input  logic [7:0] wrdataH,
  output logic fullH,
  output logic emptyH,
  output logic [DEPTH_LOG2:0] countH,
  output logic xmitH,
  output logic [7:0] xmitdataH,
  input  logic xmitdoneH,
  output logic tmoH
`ifdef UART_TXF_OVF_EN
  ,
  input  logic ovfclrH,
  output logic ovfH
`endif
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int TW = $clog2(BUSY_TMO + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tmo_cnt;
  logic wr_en, pop, load, tmo_nxt;
  assign fullH = countH == CW'(2**DEPTH_LOG2);
  assign emptyH = countH == '0;
  assign wr_en = wrH && !fullH;
  assign xmitH = state == LAUNCH;
  assign pop = state == LAUNCH;
  always_comb begin
    state_nxt = state;
    tmo_nxt = 1'b0;
    case (state)
      IDLE: if (!emptyH && xmitdoneH) state_nxt = LAUNCH;
      LAUNCH: state_nxt = WAIT_BUSY;
      WAIT_BUSY:
        if (!xmitdoneH) state_nxt = WAIT_DONE;
        else if (tmo_cnt == TW'(BUSY_TMO - 1)) begin
          state_nxt = IDLE;
          tmo_nxt = 1'b1;
        end
      default: if (xmitdoneH) state_nxt = IDLE;
    endcase
    load = state == IDLE && state_nxt == LAUNCH;
  end
  always_ff @(posedge sysclk)
    if (wr_en) mem[wr_ptr] <= wrdataH;
  always_ff @(posedge sysclk or negedge sysrstl)
    if (!sysrstl) begin
      state <= IDLE;
      tmoH <= 1'b0;
      xmitdataH <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      countH <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      tmoH <= tmo_nxt;
      if (load) xmitdataH <= mem[rd_ptr];
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      countH <= countH + CW'(wr_en) - CW'(pop);
      tmo_cnt <= state == WAIT_BUSY ? tmo_cnt + TW'(1) : '0;
    end
`ifdef UART_TXF_OVF_EN
  // a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge sysclk or negedge sysrstl)
    if (!sysrstl) ovfH <= 1'b0;
    else ovfH <= (wrH && fullH) ? 1'b1 : ovfclrH ? 1'b0 : ovfH;
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed checks of FIFO buffering, launch pacing, timeout and reset.
module tb_uart_tx_feeder;
  logic sysclk = 1'b0, sysrstl = 1'b0, wrH = 1'b0, xmitdoneH = 1'b1;
  logic [7:0] wrdataH = 8'h00;
  logic fullH, emptyH, xmitH, tmoH;
  logic [4:0] countH;
  logic [7:0] xmitdataH;
`ifdef UART_TXF_OVF_EN
  logic ovfclrH = 1'b0, ovfH;
`endif
  int vectors = 0, errs = 0;
  uart_tx_feeder #(.DEPTH_LOG2(4), .BUSY_TMO(8)) dut (
    .sysclk(sysclk), .sysrstl(sysrstl), .wrH(wrH), .wrdataH(wrdataH),
    .fullH(fullH), .emptyH(emptyH), .countH(countH), .xmitH(xmitH),
    .xmitdataH(xmitdataH), .xmitdoneH(xmitdoneH), .tmoH(tmoH)
`ifdef UART_TXF_OVF_EN
    , .ovfclrH(ovfclrH), .ovfH(ovfH)
`endif
  );
  always #5 sysclk = ~sysclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    wrH = 1'b1;
    wrdataH = d;
    tick;
    wrH = 1'b0;
  endtask
  // transmitter model: wait for launch, check byte, stay busy for 'low' cycles
  task automatic serve(input logic [7:0] exp, input int low);
    int n = 0;
    while (!xmitH && n < 20) begin
      tick;
      n++;
    end
    chk("launch_seen", xmitH, 1);
    chk("launch_data", xmitdataH, exp);
    tick;
    chk("strobe_one_cycle", xmitH, 0);
    xmitdoneH = 1'b0;
    repeat (low) tick;
    xmitdoneH = 1'b1;
    tick;
  endtask
  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      tick;
      seen += int'(xmitH);
    end
    chk(tag, seen, 0);
  endtask
  initial begin
    int seen;
    #12;
    chk("rst_count", countH, 0);
    chk("rst_empty", emptyH, 1);
    chk("rst_full", fullH, 0);
    chk("rst_xmit", xmitH, 0);
    chk("rst_data", xmitdataH, 0);
    chk("rst_tmo", tmoH, 0);
`ifdef UART_TXF_OVF_EN
    chk("rst_ovf", ovfH, 0);
`endif
    sysrstl = 1'b1;
    tick;
    wr(8'hA5);
    chk("lat_n1_count", countH, 1);
    chk("lat_n1_xmit", xmitH, 0);
    tick;
    chk("lat_n2_xmit", xmitH, 1);
    chk("lat_n2_data", xmitdataH, 8'hA5);
    tick;
    chk("lat_n3_xmit", xmitH, 0);
    chk("lat_n3_count", countH, 0);
    tick;
    xmitdoneH = 1'b0;
    seen = 0;
    repeat (160) begin
      tick;
      seen += int'(xmitH) + int'(tmoH);
    end
    chk("busy_quiet", seen, 0);
    chk("busy_data_held", xmitdataH, 8'hA5);
    xmitdoneH = 1'b1;
    tick;
    chk("a5_empty", emptyH, 1);
    quiet("a5_no_relaunch", 5);
    xmitdoneH = 1'b0;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      seen += int'(xmitH);
    end
    chk("burst_no_xmit", seen, 0);
    chk("burst_full", fullH, 1);
    chk("burst_count", countH, 16);
    wr(8'hFF);
    chk("drop_count", countH, 16);
    xmitdoneH = 1'b1;
    tick;
    chk("full_launch", xmitH, 1);
    chk("full_launch_data", xmitdataH, 8'h00);
    wr(8'hEE);
    chk("pop_drop_count", countH, 15);
    chk("pop_drop_full", fullH, 0);
    xmitdoneH = 1'b0;
    repeat (3) tick;
    xmitdoneH = 1'b1;
    tick;
    for (int i = 1; i < 16; i++) serve(8'(i), 3);
    chk("drain_empty", emptyH, 1);
    quiet("no_ff_ee", 10);
    wr(8'h11);
    wr(8'h22);
    chk("tmo_launch", xmitH, 1);
    chk("tmo_launch_data", xmitdataH, 8'h11);
    tick;
    seen = 0;
    repeat (7) begin
      tick;
      seen += int'(tmoH) + int'(xmitH);
    end
    chk("tmo_early", seen, 0);
    tick;
    chk("tmo_pulse", tmoH, 1);
    chk("tmo_idle", xmitH, 0);
    tick;
    chk("tmo_single", tmoH, 0);
    chk("tmo_next_launch", xmitH, 1);
    chk("tmo_next_data", xmitdataH, 8'h22);
    tick;
    xmitdoneH = 1'b0;
    repeat (2) tick;
    xmitdoneH = 1'b1;
    tick;
    chk("tmo_done_empty", emptyH, 1);
    xmitdoneH = 1'b0;
    for (int i = 0; i < 6; i++) wr(8'h30 + 8'(i));
    xmitdoneH = 1'b1;
    tick;
    chk("rst_launch", xmitH, 1);
    xmitdoneH = 1'b0;
    tick;
    tick;
    chk("rst_pre_count", countH, 5);
    #3;
    sysrstl = 1'b0;
    #1;
    chk("arst_count", countH, 0);
    chk("arst_empty", emptyH, 1);
    chk("arst_xmit", xmitH, 0);
    chk("arst_data", xmitdataH, 0);
    tick;
    sysrstl = 1'b1;
    xmitdoneH = 1'b1;
    quiet("post_rst_quiet", 10);
    wr(8'h77);
    serve(8'h77, 2);
`ifdef UART_TXF_OVF_EN
    xmitdoneH = 1'b0;
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i));
    chk("ovf_none", ovfH, 0);
    wr(8'h99);
    chk("ovf_set", ovfH, 1);
    wrH = 1'b1;
    ovfclrH = 1'b1;
    tick;
    chk("ovf_set_wins", ovfH, 1);
    wrH = 1'b0;
    tick;
    ovfclrH = 1'b0;
    chk("ovf_clr", ovfH, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO with launch controller, directly upstream of the UART transmitter.
- Accepts bytes from a host write port and buffers them.
- Presents one byte at a time on xmitdataH with a single-cycle xmitH strobe, then paces on the transmitter's xmitdoneH level (high = idle/ready).
- Lets the host burst bytes without polling per-frame completion.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (default 16)
BUSY_TMO, 8, max cycles in WAIT_BUSY for xmitdoneH to fall before abandoning the launch

Ports:
sysclk  in  1  clock
sysrstl  in  1  asynchronous active-low reset
wrH  in  1  host write strobe, one byte per cycle
wrdataH  in  8  host write data
fullH  out  1  FIFO full (count == 2**DEPTH_LOG2)
emptyH  out  1  FIFO empty (count == 0)
countH  out  DEPTH_LOG2+1  entries held
xmitH  out  1  one-cycle launch strobe to transmitter
xmitdataH  out  8  byte to transmit; held stable from launch until return to IDLE
xmitdoneH  in  1  transmitter idle/done level
tmoH  out  1  one-cycle pulse when a launch times out

Behaviour:
- Decided: reset sysrstl, asynchronous, active-low; clock sysclk.
- Reset values: countH=0, emptyH=1, fullH=0, xmitH=0, xmitdataH=8'h00, tmoH=0, rd/wr pointers=0, state=IDLE. Reset mid-frame discards all buffered bytes and drops xmitH immediately.
- FIFO:
  - Write accepted when wrH && !fullH; wrdataH goes to wr pointer, pointer +1 mod depth.
  - Write while fullH=1 is dropped. fullH is registered count, so a pop in the same cycle does not rescue the write.
  - Pop occurs in LAUNCH only. Simultaneous accepted write and pop leaves count unchanged.
  - Pointers are DEPTH_LOG2 bits and wrap naturally.
- State machine (registered, 2-bit encoding):
  - IDLE: if !emptyH && xmitdoneH -> LAUNCH, loading xmitdataH <= mem[rd] at the transition; else stay.
  - LAUNCH: xmitH=1 for exactly this cycle; rd pointer +1, count -1; -> WAIT_BUSY; timeout counter cleared.
  - WAIT_BUSY: if !xmitdoneH -> WAIT_DONE; else if counter == BUSY_TMO-1 -> IDLE with tmoH=1 for one cycle (byte considered lost, not re-queued); else counter +1.
  - WAIT_DONE: if xmitdoneH -> IDLE; no timeout (frame length is owned by the transmitter).
- Latency: write into empty FIFO at cycle N with xmitdoneH=1 -> count=1 at N+1 -> state LAUNCH and xmitH=1 at N+2.
- Minimum gap between launches: LAUNCH + WAIT_BUSY(>=1) + WAIT_DONE(>=1) + IDLE = 4 cycles.
- xmitH is never asserted outside LAUNCH; never two consecutive cycles.
- xmitdataH changes only on the IDLE->LAUNCH transition.

Optional Feature:
- Macro: UART_TXF_OVF_EN.
- Defined: adds input ovfclrH (1) and output ovfH (1). ovfH is a sticky flag, reset 0, set the cycle after a write is dropped on full, cleared by ovfclrH. Set wins over a simultaneous clear.
- Undefined: neither port exists; dropped writes are silent.

Test Plan:
- Reset then single write 8'hA5 at cycle N, xmitdoneH=1 -> xmitH=1 at N+2 only, xmitdataH=8'hA5, countH back to 0 at N+3; model drops xmitdoneH 2 cycles later, raises after 160 -> state IDLE, emptyH=1.
- Burst 16 writes 8'h00..8'h0F with xmitdoneH=0 held -> fullH=1, countH=16, no xmitH; 17th write 8'hFF dropped; release transmitter model -> 16 launches in order 00..0F, FF never sent.
- Full FIFO, write coincides with LAUNCH pop -> write dropped, countH goes 16->15.
- xmitdoneH held 1 after launch (dead transmitter) -> tmoH pulses exactly BUSY_TMO=8 cycles after the WAIT_BUSY entry, state IDLE, next byte launched.
- Assert sysrstl=0 during WAIT_DONE with 5 bytes queued -> countH=0, xmitH=0, xmitdataH=0 immediately; no launch after release until a new write.
- With UART_TXF_OVF_EN: overflow write -> ovfH=1 next cycle; ovfclrH pulse with simultaneous overflow -> ovfH stays 1; ovfclrH alone -> ovfH=0.
